// File: rtl/matriz_pkg.sv
// Shared definitions for the LED matrix puzzle.
// Holds the default 8x8 toggle-mask table (one 64-bit mask per button,
// bit index = row*8 + col), the win-row requirement function and the
// cell-index width of the default table.
package matriz_pkg;

  localparam int unsigned DEF_DIM    = 8;
  localparam int unsigned DEF_BOTOES = 8;
  localparam int unsigned CELL_W     = $clog2(DEF_DIM * DEF_DIM);
  localparam int unsigned BOTAO_W    = $clog2(DEF_BOTOES);

  // Byte r of each mask is row r; bit c within the byte is column c.
  localparam logic [DEF_BOTOES-1:0][DEF_DIM*DEF_DIM-1:0] MASCARA = {
    64'hE0E0_E000_0000_0000,  // b7: rows 5-7, cols 5-7
    64'h8040_2010_0804_0201,  // b6: main diagonal
    64'h0303_0300_0000_0000,  // b5: rows 5-7, cols 0-1
    64'h0000_00FF_FF00_0000,  // b4: rows 3-4, all cols
    64'h1818_1800_0000_0000,  // b3: rows 5-7, cols 3-4
    64'h0C0C_0C00_0000_0000,  // b2: rows 5-7, cols 2-3
    64'h0000_0000_00F8_F8F8,  // b1: rows 0-2, cols 3-7
    64'h0000_0000_0007_0707   // b0: rows 0-2, cols 0-2
  };

  // Rows that must be lit to clear a level: min(2*nivel+1, n_linhas).
  function automatic int unsigned req_linhas(input logic [2:0] nivel,
                                             input int unsigned n_linhas);
    int unsigned r;
    r = 32'd2 * 32'(nivel) + 32'd1;
    return (r < n_linhas) ? r : n_linhas;
  endfunction

  // Default-table bit for button b at (r,c); cells outside 8x8 are never
  // toggled and buttons beyond 8 reuse the table cyclically.
  function automatic logic mascara_bit(input int unsigned b,
                                       input int unsigned r,
                                       input int unsigned c);
    if (r >= DEF_DIM || c >= DEF_DIM) return 1'b0;
    return MASCARA[BOTAO_W'(b % DEF_BOTOES)][CELL_W'(r * DEF_DIM + c)];
  endfunction

  // Counter width that stays >= 1 bit for n == 1.
  function automatic int unsigned largura(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matriz_leds_param_if.sv
// Board-side bundle of the LED matrix puzzle.
// master drives: botoes (button levels), nivel (player level), limpar (clear).
// slave drives:  nivel_concluido, vitoria_pulso, colunas (active row drive),
//                linhas (active row index), jogadas (accepted-press count).
interface matriz_leds_param_if #(
  parameter int unsigned N_BOTOES = 8,
  parameter int unsigned LINHAS   = 8,
  parameter int unsigned COLUNAS  = 8
) ();

  localparam int unsigned LIN_W = $clog2(LINHAS);

  logic [N_BOTOES-1:0] botoes;
  logic [2:0]          nivel;
  logic                limpar;
  logic                nivel_concluido;
  logic                vitoria_pulso;
  logic [COLUNAS-1:0]  colunas;
  logic [LIN_W-1:0]    linhas;
  logic [7:0]          jogadas;

  modport master (
    output botoes, nivel, limpar,
    input  nivel_concluido, vitoria_pulso, colunas, linhas, jogadas
  );

  modport slave (
    input  botoes, nivel, limpar,
    output nivel_concluido, vitoria_pulso, colunas, linhas, jogadas
  );

endinterface

// File: rtl/matriz_varredura.sv
// Free-running row scanner: a prescaler counts 0..PRESC-1 and each wrap
// advances the active row, which itself wraps from LINHAS-1 to 0.
// Ports: clk, rst (sync, active high), linhas (active row, registered),
//        avanco_c (combinational tick on the last prescaler count).
module matriz_varredura
  import matriz_pkg::*;
#(
  parameter int unsigned LINHAS = 8,
  parameter int unsigned PRESC  = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [$clog2(LINHAS)-1:0] linhas,
  output logic                      avanco_c
);

  localparam int unsigned CNT_W = largura(PRESC);
  localparam int unsigned LIN_W = $clog2(LINHAS);

  logic [CNT_W-1:0] r_presc;
  logic [LIN_W-1:0] r_linha;

  assign avanco_c = (r_presc == CNT_W'(PRESC - 1));

  // Prescaler and row index; explicit wrap handles non-power-of-2 LINHAS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_linha <= '0;
    end else if (avanco_c) begin
      r_presc <= '0;
      r_linha <= (r_linha == LIN_W'(LINHAS - 1)) ? '0 : r_linha + LIN_W'(1);
    end else begin
      r_presc <= r_presc + CNT_W'(1);
    end
  end

  assign linhas = r_linha;

endmodule

// File: rtl/matriz_leds_param.sv
// LED matrix "lights out" style puzzle with row-multiplexed display.
// Each rising button edge XORs that button's mask into the board; the win
// flag is raised when the first min(2*nivel+1, LINHAS) rows are all lit.
// Ports: clk, rst (sync, active high), bus (matriz_leds_param_if.slave).
// Optional feature: define MATRIZ_CONTADOR_JOGADAS_EN to enable the
// saturating accepted-press counter on jogadas (tied to 0 otherwise).
module matriz_leds_param
  import matriz_pkg::*;
#(
  parameter int unsigned LINHAS   = 8,
  parameter int unsigned COLUNAS  = 8,
  parameter int unsigned N_BOTOES = 8,
  parameter int unsigned PRESC    = 1000
) (
  input  logic                clk,
  input  logic                rst,
  matriz_leds_param_if.slave  bus
);

  localparam int unsigned CELULAS = LINHAS * COLUNAS;
  localparam int unsigned LIN_W   = $clog2(LINHAS);

  logic [N_BOTOES-1:0]               r_botoes_ant;
  logic                              r_armado;
  logic [CELULAS-1:0]                r_tabuleiro;
  logic                              r_nivel_concluido;
  logic                              r_vitoria_pulso;

  logic [N_BOTOES-1:0]               w_bordas;
  logic [N_BOTOES-1:0][CELULAS-1:0]  w_mascaras;
  logic [N_BOTOES:0][CELULAS-1:0]    w_acum;
  logic [LINHAS-1:0]                 w_linha_cheia;
  logic [LINHAS-1:0]                 w_linha_exigida;
  logic [COLUNAS-1:0]                w_matriz [LINHAS];
  logic [LIN_W-1:0]                  w_linhas;
  logic                              w_avanco;
  logic                              w_vence;
  int unsigned                       w_req;

  // r_armado suppresses edges for one cycle after reset so a button held
  // across reset is seen as already pressed.
  assign w_bordas = r_armado ? (bus.botoes & ~r_botoes_ant) : '0;

  // Per-button mask expansion and XOR of all masks with an edge this cycle.
  assign w_acum[0] = '0;
  for (genvar gb = 0; gb < N_BOTOES; gb++) begin : g_botao
    for (genvar gr = 0; gr < LINHAS; gr++) begin : g_lin
      for (genvar gc = 0; gc < COLUNAS; gc++) begin : g_col
        assign w_mascaras[gb][gr*COLUNAS+gc] = mascara_bit(gb, gr, gc);
      end
    end
    assign w_acum[gb+1] = w_acum[gb] ^ (w_bordas[gb] ? w_mascaras[gb] : '0);
  end

  // Row view of the board and win evaluation.
  assign w_req = req_linhas(bus.nivel, LINHAS);
  for (genvar gr = 0; gr < LINHAS; gr++) begin : g_linha
    assign w_matriz[gr]        = r_tabuleiro[gr*COLUNAS +: COLUNAS];
    assign w_linha_cheia[gr]   = &w_matriz[gr];
    assign w_linha_exigida[gr] = (32'(gr) < w_req);
  end
  assign w_vence = (bus.nivel < 3'd5) && (&(w_linha_cheia | ~w_linha_exigida));

  // Board, edge history and win flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_botoes_ant      <= '0;
      r_armado          <= 1'b0;
      r_tabuleiro       <= '0;
      r_nivel_concluido <= 1'b0;
      r_vitoria_pulso   <= 1'b0;
    end else begin
      r_botoes_ant      <= bus.botoes;
      r_armado          <= 1'b1;
      r_tabuleiro       <= bus.limpar ? '0 : (r_tabuleiro ^ w_acum[N_BOTOES]);
      r_nivel_concluido <= w_vence;
      r_vitoria_pulso   <= w_vence & ~r_nivel_concluido;
    end
  end

`ifdef MATRIZ_CONTADOR_JOGADAS_EN
  logic [7:0] r_jogadas;

  // One count per cycle with any accepted edge, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst || bus.limpar) begin
      r_jogadas <= '0;
    end else if ((|w_bordas) && (r_jogadas != 8'hFF)) begin
      r_jogadas <= r_jogadas + 8'd1;
    end
  end

  assign bus.jogadas = r_jogadas;
`else
  assign bus.jogadas = '0;
`endif

  matriz_varredura #(
    .LINHAS (LINHAS),
    .PRESC  (PRESC)
  ) u_varredura (
    .clk      (clk),
    .rst      (rst),
    .linhas   (w_linhas),
    .avanco_c (w_avanco)
  );

  // The tick is only needed internally by the scanner.
  logic w_avanco_nc;
  assign w_avanco_nc = w_avanco;

  assign bus.linhas          = w_linhas;
  assign bus.colunas         = w_matriz[w_linhas];
  assign bus.nivel_concluido = r_nivel_concluido;
  assign bus.vitoria_pulso   = r_vitoria_pulso;

endmodule

// File: tb/tb_matriz_leds_param.sv
// Scoreboard bench: a cycle-level model of the puzzle rules pushes the
// expected outputs for every clock; a monitor pops and compares them.
module tb_matriz_leds_param;

  localparam int NB = 8;
  localparam int L  = 8;
  localparam int C  = 8;
  localparam int PR = 4;
  localparam int L5 = 5;
  localparam int PR5 = 3;

  typedef bit board_t [16][16];
  typedef struct {
    int lin; int col; int nc; int vit; int jog;
    int lin5; int col5; int nc5;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  matriz_leds_param_if #(.N_BOTOES(NB), .LINHAS(L),  .COLUNAS(C)) bus  ();
  matriz_leds_param_if #(.N_BOTOES(NB), .LINHAS(L5), .COLUNAS(C)) bus5 ();

  assign bus5.botoes = bus.botoes;
  assign bus5.nivel  = bus.nivel;
  assign bus5.limpar = bus.limpar;

  matriz_leds_param #(.LINHAS(L), .COLUNAS(C), .N_BOTOES(NB), .PRESC(PR)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  matriz_leds_param #(.LINHAS(L5), .COLUNAS(C), .N_BOTOES(NB), .PRESC(PR5)) u_dut5 (
    .clk (clk), .rst (rst), .bus (bus5)
  );

  always #5 clk = ~clk;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  board_t tab, tab5;
  logic [7:0] prev;
  bit     blk, nc, vit, cont_en;
  int     k, jog;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // Button footprints described as rectangles / diagonal on an 8x8 grid.
  function automatic bit in_mask(input int b, input int r, input int c);
    case (b % 8)
      0:       return (r <= 2) && (c <= 2);
      1:       return (r <= 2) && (c >= 3);
      2:       return (r >= 5) && (c == 2 || c == 3);
      3:       return (r >= 5) && (c == 3 || c == 4);
      4:       return (r == 3) || (r == 4);
      5:       return (r >= 5) && (c <= 1);
      6:       return r == c;
      default: return (r >= 5) && (c >= 5);
    endcase
  endfunction

  function automatic bit ganha(input board_t t, input int nl, input int niv);
    int req;
    if (niv >= 5) return 1'b0;
    req = 2 * niv + 1;
    if (req > nl) req = nl;
    for (int r = 0; r < req; r++)
      for (int c = 0; c < C; c++)
        if (!t[r][c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic board_t atualiza(input board_t t, input int nl, input logic [7:0] acc);
    board_t n;
    n = t;
    for (int r = 0; r < nl; r++)
      for (int c = 0; c < C; c++) begin
        bit p;
        p = 1'b0;
        for (int b = 0; b < NB; b++)
          if (acc[b] && in_mask(b, r, c)) p = ~p;
        n[r][c] = t[r][c] ^ p;
      end
    return n;
  endfunction

  function automatic int linha_val(input board_t t, input int r);
    int v;
    v = 0;
    for (int c = 0; c < C; c++) if (t[r][c]) v = v | (1 << c);
    return v;
  endfunction

  // Reference model: state after the clock edge that closes this cycle.
  task automatic passo(input bit r, input bit l, input logic [7:0] b, input logic [2:0] n);
    exp_t e;
    logic [7:0] acc;
    bit nn;
    if (r) begin
      tab = '{default: 0}; tab5 = '{default: 0};
      jog = 0; nc = 0; vit = 0; k = 0;
      e.nc5 = 0;
    end else begin
      acc = blk ? 8'h00 : (b & ~prev);
      nn  = ganha(tab, L, int'(n));
      vit = nn && !nc;
      nc  = nn;
      e.nc5 = int'(ganha(tab5, L5, int'(n)));
      if (l) begin
        tab = '{default: 0}; tab5 = '{default: 0}; jog = 0;
      end else begin
        tab  = atualiza(tab, L, acc);
        tab5 = atualiza(tab5, L5, acc);
        if (cont_en && acc != 8'h00 && jog < 255) jog++;
      end
      k++;
    end
    prev = b;
    blk  = r;
    e.lin  = (k / PR) % L;
    e.col  = linha_val(tab, e.lin);
    e.nc   = int'(nc);
    e.vit  = int'(vit);
    e.jog  = jog;
    e.lin5 = (k / PR5) % L5;
    e.col5 = linha_val(tab5, e.lin5);
    q.push_back(e);
  endtask

  task automatic ciclo(input bit r, input bit l, input logic [7:0] b, input logic [2:0] n);
    @(negedge clk);
    rst        = r;
    bus.limpar = l;
    bus.botoes = b;
    bus.nivel  = n;
    passo(r, l, b, n);
  endtask

  // Monitor: outputs are presented every cycle; compare #1 after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("linhas",           int'(bus.linhas),           e.lin);
        chk("colunas",          int'(bus.colunas),          e.col);
        chk("nivel_concluido",  int'(bus.nivel_concluido),  e.nc);
        chk("vitoria_pulso",    int'(bus.vitoria_pulso),    e.vit);
        chk("jogadas",          int'(bus.jogadas),          e.jog);
        chk("linhas5",          int'(bus5.linhas),          e.lin5);
        chk("colunas5",         int'(bus5.colunas),         e.col5);
        chk("nivel_concluido5", int'(bus5.nivel_concluido), e.nc5);
      end
    end
  end

  initial begin : driver
    logic [7:0] b;
    bus.botoes = '0;
    bus.nivel  = '0;
    bus.limpar = 1'b0;
    prev = '0; blk = 1'b1; k = 0; jog = 0; nc = 0; vit = 0;
    tab = '{default: 0}; tab5 = '{default: 0};
`ifdef MATRIZ_CONTADOR_JOGADAS_EN
    cont_en = 1'b1;
`else
    cont_en = 1'b0;
`endif

    repeat (3) ciclo(1, 0, 8'h00, 3'd0);
    repeat (2) ciclo(0, 0, 8'h00, 3'd0);

    // Single press held: toggles once, then full scan of the board.
    repeat (10) ciclo(0, 0, 8'h01, 3'd0);
    repeat (34) ciclo(0, 0, 8'h00, 3'd0);

    // Two overlapping masks in the same cycle.
    ciclo(0, 1, 8'h00, 3'd0);
    ciclo(0, 0, 8'h00, 3'd0);
    repeat (3) ciclo(0, 0, 8'h0C, 3'd0);
    repeat (34) ciclo(0, 0, 8'h00, 3'd0);

    // Fill rows 0-2, then sweep levels (win, lose by level, disabled >=5).
    ciclo(0, 1, 8'h00, 3'd0);
    ciclo(0, 0, 8'h00, 3'd0);
    ciclo(0, 0, 8'h01, 3'd0);
    ciclo(0, 0, 8'h00, 3'd0);
    ciclo(0, 0, 8'h02, 3'd0);
    repeat (6) ciclo(0, 0, 8'h00, 3'd0);
    for (int n = 0; n < 8; n++) repeat (4) ciclo(0, 0, 8'h00, 3'(n));
    repeat (4) ciclo(0, 0, 8'h00, 3'd0);
    ciclo(0, 0, 8'h01, 3'd0);
    repeat (4) ciclo(0, 0, 8'h00, 3'd0);

    // Clear coinciding with an edge, button kept held afterwards.
    ciclo(0, 1, 8'h10, 3'd0);
    repeat (3) ciclo(0, 0, 8'h10, 3'd0);
    repeat (34) ciclo(0, 0, 8'h00, 3'd0);

    // Reset while a button is held: no toggle until released and re-pressed.
    ciclo(0, 0, 8'h01, 3'd0);
    repeat (2) ciclo(1, 0, 8'h01, 3'd0);
    repeat (5) ciclo(0, 0, 8'h01, 3'd0);
    ciclo(0, 0, 8'h00, 3'd0);
    ciclo(0, 0, 8'h01, 3'd0);
    repeat (34) ciclo(0, 0, 8'h00, 3'd0);

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 500; i++) begin
      b = bus.botoes;
      if ($urandom_range(0, 2) == 0) b = 8'($urandom);
      ciclo($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, b,
            3'($urandom_range(0, 7)));
    end

    // 300 separate presses: counter saturates when enabled.
    ciclo(0, 1, 8'h00, 3'd0);
    for (int i = 0; i < 300; i++) begin
      ciclo(0, 0, 8'h40, 3'd0);
      ciclo(0, 0, 8'h00, 3'd0);
    end
    repeat (4) ciclo(0, 0, 8'h00, 3'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
